// File: rtl/data_ram_responder_pkg.sv
// Shared types and defaults for the data RAM responder slice.
package data_ram_responder_pkg;

    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE = 1'b0;

    typedef logic [31:0] ram_addr_t;
    typedef logic [3:0]  byte_en_t;

    typedef enum logic [1:0] {
        DRAM_IDLE,
        DRAM_ACCESS,
        DRAM_RESP
    } dram_state_t;

    localparam int unsigned DRAM_WAIT_DEFAULT  = 2;
    localparam int unsigned DRAM_DEPTH_DEFAULT = 1024;

    // Byte offset is unusable if not word aligned or past the last word.
    // Widened compare so a large depth cannot overflow the bound.
    function automatic logic dram_addr_err(input ram_addr_t offset, input int unsigned depth);
        return (offset[1:0] != 2'b00) || (64'(offset) >= (64'(depth) * 64'd4));
    endfunction

endpackage

// File: rtl/data_ram_responder_dram_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module dram_array
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DRAM_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic                           i_we,
    input  byte_en_t                       i_be,
    input  logic [31:0]                    i_wdata,
    input  logic                           i_re,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane writes and read-enabled output register; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM responder: one request at a time, programmable stall,
// byte-lane stores / word loads, and error flagging for bad addresses.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DRAM_DEPTH_DEFAULT,
    parameter int unsigned WAIT_STATES = DRAM_WAIT_DEFAULT,
    parameter ram_addr_t   BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  reset_status_t rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  ram_addr_t     req_addr,
    input  byte_en_t      req_be,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES);

    dram_state_t   r_state;
    dram_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    ram_addr_t     r_addr;
    byte_en_t      r_be;
    logic [31:0]   r_wdata;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic          r_rd_sel;

    logic          w_accept;
    logic          w_do_access;
    ram_addr_t     w_offset;
    logic          w_err;
    logic [AW-1:0] w_index;
    logic          w_arr_we;
    logic          w_arr_re;
    logic [31:0]   w_arr_rdata;

    assign w_accept    = req_valid & r_req_ready;
    assign w_do_access = (r_state == DRAM_ACCESS) && (r_cnt == '0);
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_err       = dram_addr_err(w_offset, DEPTH_WORDS);
    assign w_index     = w_offset[AW+1:2];
    assign w_arr_we    = w_do_access & r_we & ~w_err;
    assign w_arr_re    = w_do_access & ~r_we & ~w_err;

    // Next-state selection for the accept / stall / respond sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DRAM_IDLE:   if (w_accept)    w_state_nxt = DRAM_ACCESS;
            DRAM_ACCESS: if (w_do_access) w_state_nxt = DRAM_RESP;
            DRAM_RESP:   if (resp_ready)  w_state_nxt = DRAM_IDLE;
            default:                      w_state_nxt = DRAM_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low through reset and
    // only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state     <= DRAM_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == DRAM_IDLE);
        end
    end

    // Request capture at the accept edge and the wait-state countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= WAIT_LOAD;
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_be    <= req_be;
            r_wdata <= req_wdata;
        end else if ((r_state == DRAM_ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Response flags; load data comes straight from the array's read register,
    // which only reloads on an access, so it is stable for the whole RESP phase.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_sel     <= 1'b0;
        end else if (w_do_access) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_rd_sel     <= ~r_we & ~w_err;
        end else if ((r_state == DRAM_RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    dram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_index),
        .i_we    (w_arr_we),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .i_re    (w_arr_re),
        .o_rdata (w_arr_rdata)
    );

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;

endmodule
